channel_err_injector: RTL and testbench
=======================================

// Module: channel_err_injector
// PURPOSE
//  Channel model between the convolutional encoder (encoder2) and the Viterbi decoder.
//  - Takes the encoder's valid-qualified 2-bit symbols.
//  - Corrupts selected symbols by XOR with a programmable mask: periodic, pseudo-random or burst.
//  - Forwards them one cycle later and counts every injected error, so the bench can score the decoder.
//  - Injection is limited to the first WINDOW accepted symbols.
// PARAMETERS
//  N         4        periodic/burst trigger when word_ct[N-1:0]=='1 (every 2^N symbols)
//  WINDOW    256      symbols eligible for injection; word_ct saturates here
//  CW        16       width of word/injection counters
//  LFSR_SEED 16'hACE1 LFSR reset value; a value of 0 is replaced by 16'hACE1
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-high reset
//  enable_i       in   1   d_in valid this cycle (encoder valid_o)
//  d_in           in   2   encoder symbol
//  mode_i         in   2   00 off, 01 periodic, 10 random, 11 burst
//  err_mask_i     in   2   bits XORed into a corrupted symbol
//  thresh_i       in   8   random mode: inject when lfsr[7:0] < thresh_i
//  burst_len_i    in   4   burst mode: symbols per burst (0 treated as 1)
//  valid_o        out  1   d_out valid (feeds decoder enable)
//  d_out          out  2   possibly corrupted symbol
//  err_flag_o     out  1   d_out was corrupted (mask != 0)
//  inj_sym_ct_o   out  CW  corrupted-symbol count, saturating
//  inj_bit_ct_o   out  CW  flipped-bit count (+popcount(mask)), saturating
//  word_ct_o      out  CW  accepted-symbol count, saturates at WINDOW
//  window_done_o  out  1   sticky: word_ct_o reached WINDOW
// BEHAVIOUR
//  - Reset (async, any time, including mid-burst):
//    - All outputs go to 0; FSM goes to IDLE; lfsr loads LFSR_SEED.
//    - Effect is immediate, not clock-aligned.
//  - Accepted symbol = clk edge with enable_i=1. All state advances only on accepted symbols.
//    - With enable_i=0: valid_o=0, err_flag_o=0; d_out, counters, lfsr and FSM hold.
//  - Latency is 1 cycle:
//    - valid_o <= enable_i
//    - d_out   <= d_in ^ (inj ? err_mask_i : 2'b00)
//    - err_flag_o <= inj && |err_mask_i
//  - Eligibility: elig = (word_ct < WINDOW). inj is always 0 when !elig.
//  - word_ct increments per accepted symbol until it reaches WINDOW.
//    - window_done_o is set on the accepted symbol that makes word_ct == WINDOW.
//    - window_done_o stays set until reset.
//  - Injection decision per mode, evaluated on the pre-increment word_ct:
//    - 00: inj=0.
//    - 01: inj = (word_ct[N-1:0]=='1).
//    - 10: inj = (lfsr[7:0] < thresh_i).
//      - thresh_i=0 gives no injection; 255 injects unless lfsr[7:0]==255.
//    - 11: inj from the burst FSM.
//  - LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11 (shift right, XOR 16'hB400 when lsb=1).
//    - Steps on every accepted symbol in every mode; the decision uses the pre-step value.
//  - Burst FSM: states IDLE, BURST; rem is a 4-bit count.
//    - IDLE: if word_ct[N-1:0]=='1, inj=1.
//      - Go to BURST with rem = max(burst_len_i,1)-1 when that is nonzero; otherwise stay in IDLE.
//    - BURST: inj=1; rem decrements; go to IDLE when rem reaches 0.
//      - Periodic triggers inside BURST are ignored.
//    - Any mode_i != 11 forces IDLE immediately; a burst is never resumed.
//    - A burst that crosses WINDOW is truncated (inj=0 once !elig); the FSM still runs to IDLE.
//  - Counters (update only on corrupted symbols, i.e. inj && |err_mask_i):
//    - inj_sym_ct += 1 and inj_bit_ct += popcount(err_mask_i).
//    - Both saturate at 2^CW-1.
//    - mask=00 leaves data and counters untouched.
//  - mode_i, err_mask_i, thresh_i and burst_len_i are sampled on each accepted symbol.
//    - Changing them mid-stream is legal and affects that symbol.
// TESTING
//  - mode=01, mask=11, 32 back-to-back symbols d_in=00:
//    - d_out=11 on symbols 15 and 31; err_flag_o is high on exactly those two outputs.
//    - inj_sym_ct=2, inj_bit_ct=4.
//  - mode=00, 300 symbols of random data:
//    - d_out==d_in delayed 1 cycle; counters stay 0.
//    - window_done_o rises with the output of symbol 255; word_ct_o holds at 256.
//  - mode=11, burst_len=3, mask=01, 40 symbols:
//    - Bit0 flipped on symbols 15,16,17 and 31,32,33; inj_bit_ct=6.
//    - burst_len=0 flips only 15 and 31.
//  - enable_i toggled 1-0-1-0, mode=01:
//    - Same symbol-indexed corruption as the first test; valid_o mirrors the gaps.
//    - Counters and d_out hold during gaps.
//  - mode=10, thresh=0, then thresh=128, 1000 symbols:
//    - thresh=0 gives no injections.
//    - thresh=128 matches a bit-exact LFSR model from seed 16'hACE1, checked symbol by symbol.
//  - rst pulsed during a burst (symbol 16):
//    - Outputs are 0 before the next edge.
//    - After release, word_ct restarts at 0 and the next burst begins at symbol 15.

Source files
------------

// File: rtl/channel_err_injector.sv
// Channel model between encoder2 and the Viterbi decoder: corrupts 2-bit symbols
// (periodic, LFSR-random or burst), forwards them one cycle later and counts injected errors.
module channel_err_injector #(
    parameter int unsigned N         = 4,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned CW        = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_i,
    input  logic [1:0]    d_in,
    input  logic [1:0]    mode_i,
    input  logic [1:0]    err_mask_i,
    input  logic [7:0]    thresh_i,
    input  logic [3:0]    burst_len_i,
    output logic          valid_o,
    output logic [1:0]    d_out,
    output logic          err_flag_o,
    output logic [CW-1:0] inj_sym_ct_o,
    output logic [CW-1:0] inj_bit_ct_o,
    output logic [CW-1:0] word_ct_o,
    output logic          window_done_o
);

    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [15:0]   SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [CW-1:0] WIN  = CW'(WINDOW);

    state_t        state_q, state_d;
    logic [3:0]    rem_q, rem_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [CW-1:0] word_ct_q, word_ct_d;
    logic [CW-1:0] sym_ct_q, sym_ct_d;
    logic [CW-1:0] bit_ct_q, bit_ct_d;
    logic          valid_q, valid_d;
    logic [1:0]    d_out_q, d_out_d;
    logic          err_flag_q, err_flag_d;
    logic          wdone_q, wdone_d;

    logic          elig, trig, burst_inj, inj_raw, inj, corrupt;
    logic [3:0]    blen_eff;
    logic [1:0]    pop;
    logic [CW:0]   bit_sum;

    always_comb begin
        elig      = (word_ct_q < WIN);
        trig      = &word_ct_q[N-1:0];
        blen_eff  = (burst_len_i == 4'd0) ? 4'd1 : burst_len_i;
        pop       = {1'b0, err_mask_i[1]} + {1'b0, err_mask_i[0]};

        state_d   = state_q;
        rem_d     = rem_q;
        burst_inj = 1'b0;
        // Leaving burst mode abandons any burst in flight, even between accepted symbols.
        if (mode_i != 2'b11) begin
            state_d = IDLE;
            rem_d   = '0;
        end else if (enable_i) begin
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        burst_inj = 1'b1;
                        if (blen_eff != 4'd1) begin
                            state_d = BURST;
                            rem_d   = blen_eff - 4'd1;
                        end
                    end
                end
                BURST: begin
                    burst_inj = 1'b1;
                    rem_d     = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        case (mode_i)
            2'b01:   inj_raw = trig;
            2'b10:   inj_raw = (lfsr_q[7:0] < thresh_i);
            2'b11:   inj_raw = burst_inj;
            default: inj_raw = 1'b0;
        endcase
        inj     = inj_raw && elig;
        corrupt = inj && (|err_mask_i);
        bit_sum = {1'b0, bit_ct_q} + (CW+1)'(pop);

        valid_d    = enable_i;
        err_flag_d = 1'b0;
        d_out_d    = d_out_q;
        lfsr_d     = lfsr_q;
        word_ct_d  = word_ct_q;
        wdone_d    = wdone_q;
        sym_ct_d   = sym_ct_q;
        bit_ct_d   = bit_ct_q;

        if (enable_i) begin
            d_out_d    = d_in ^ (inj ? err_mask_i : 2'b00);
            err_flag_d = corrupt;
            lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
            if (elig) begin
                word_ct_d = word_ct_q + 1'b1;
                if (word_ct_d == WIN) wdone_d = 1'b1;
            end
            if (corrupt) begin
                if (sym_ct_q != '1) sym_ct_d = sym_ct_q + 1'b1;
                bit_ct_d = bit_sum[CW] ? '1 : bit_sum[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            lfsr_q     <= SEED;
            word_ct_q  <= '0;
            sym_ct_q   <= '0;
            bit_ct_q   <= '0;
            valid_q    <= 1'b0;
            d_out_q    <= '0;
            err_flag_q <= 1'b0;
            wdone_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            lfsr_q     <= lfsr_d;
            word_ct_q  <= word_ct_d;
            sym_ct_q   <= sym_ct_d;
            bit_ct_q   <= bit_ct_d;
            valid_q    <= valid_d;
            d_out_q    <= d_out_d;
            err_flag_q <= err_flag_d;
            wdone_q    <= wdone_d;
        end
    end

    assign valid_o       = valid_q;
    assign d_out         = d_out_q;
    assign err_flag_o    = err_flag_q;
    assign inj_sym_ct_o  = sym_ct_q;
    assign inj_bit_ct_o  = bit_ct_q;
    assign word_ct_o     = word_ct_q;
    assign window_done_o = wdone_q;

endmodule

// File: tb/tb_channel_err_injector.sv
// Scoreboard bench for channel_err_injector: stimulus pushes expected outputs,
// a monitor pops and compares whenever valid_o is high and checks hold behaviour in gaps.
module tb_channel_err_injector;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable_i = 1'b0;
    logic [1:0]  d_in = '0;
    logic [1:0]  mode_i = '0;
    logic [1:0]  err_mask_i = '0;
    logic [7:0]  thresh_i = '0;
    logic [3:0]  burst_len_i = '0;
    logic        valid_o;
    logic [1:0]  d_out;
    logic        err_flag_o;
    logic [15:0] inj_sym_ct_o;
    logic [15:0] inj_bit_ct_o;
    logic [15:0] word_ct_o;
    logic        window_done_o;

    channel_err_injector #(
        .N(4), .WINDOW(256), .CW(16), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .enable_i(enable_i), .d_in(d_in), .mode_i(mode_i),
        .err_mask_i(err_mask_i), .thresh_i(thresh_i), .burst_len_i(burst_len_i),
        .valid_o(valid_o), .d_out(d_out), .err_flag_o(err_flag_o),
        .inj_sym_ct_o(inj_sym_ct_o), .inj_bit_ct_o(inj_bit_ct_o),
        .word_ct_o(word_ct_o), .window_done_o(window_done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  d;
        logic        flag;
        logic [15:0] sc;
        logic [15:0] bc;
        logic [15:0] wc;
        logic        wd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (symbol index since reset, LFSR, running counts)
    int          idx;
    logic [15:0] m_lfsr;
    int          m_sym, m_bit;

    task automatic model_reset();
        idx    = 0;
        m_lfsr = 16'hACE1;
        m_sym  = 0;
        m_bit  = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic send(input logic en, input logic [1:0] d);
        logic inj;
        int   eff;
        exp_t e;
        @(negedge clk);
        enable_i = en;
        d_in     = d;
        if (en) begin
            eff = (burst_len_i == 4'd0) ? 1 : int'(burst_len_i);
            case (mode_i)
                2'b01:   inj = ((idx % 16) == 15);
                2'b10:   inj = (m_lfsr[7:0] < thresh_i);
                2'b11:   inj = (idx >= 15) && (((idx - 15) % 16) < eff);
                default: inj = 1'b0;
            endcase
            if (idx >= 256) inj = 1'b0;
            e.d    = d ^ (inj ? err_mask_i : 2'b00);
            e.flag = inj && (err_mask_i != 2'b00);
            if (e.flag) begin
                m_sym++;
                m_bit += int'(err_mask_i[0]) + int'(err_mask_i[1]);
            end
            idx++;
            e.sc = 16'(m_sym);
            e.bc = 16'(m_bit);
            e.wc = (idx >= 256) ? 16'd256 : 16'(idx);
            e.wd = (idx >= 256);
            m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 2'b00);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst      = 1'b1;
        enable_i = 1'b0;
        #1;
        chk("reset_outputs",
            {valid_o, d_out, err_flag_o, inj_sym_ct_o, inj_bit_ct_o, word_ct_o, window_done_o},
            64'd0);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: compares presented outputs; in gaps, outputs must hold the last symbol's values.
    initial begin
        exp_t last;
        exp_t e;
        exp_t got;
        last = '0;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                last = '0;
            end else begin
                got = {d_out, err_flag_o, inj_sym_ct_o, inj_bit_ct_o, word_ct_o, window_done_o};
                checks++;
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid got=%0h t=%0t", got, $time);
                    end else begin
                        e = sb.pop_front();
                        if (got !== e) begin
                            errors++;
                            $display("FAIL out got=%0h exp=%0h t=%0t", got, e, $time);
                        end
                        last = e;
                    end
                end else begin
                    e      = last;
                    e.flag = 1'b0;
                    if (got !== e) begin
                        errors++;
                        $display("FAIL gap_hold got=%0h exp=%0h t=%0t", got, e, $time);
                    end
                end
            end
        end
    end

    initial begin
        logic [1:0] r;
        model_reset();
        #22;
        rst = 1'b0;

        // Periodic, mask 11, zeros in: symbols 15 and 31 become 11
        mode_i = 2'b01; err_mask_i = 2'b11;
        for (int i = 0; i < 32; i++) send(1'b1, 2'b00);
        idle(3);
        chk("periodic_sym_ct", 64'(inj_sym_ct_o), 64'd2);
        chk("periodic_bit_ct", 64'(inj_bit_ct_o), 64'd4);

        // Off mode, 300 random symbols: pass-through and window saturation
        pulse_reset();
        mode_i = 2'b00;
        for (int i = 0; i < 300; i++) begin
            r = 2'($urandom_range(3, 0));
            send(1'b1, r);
        end
        idle(3);
        chk("off_word_ct", 64'(word_ct_o), 64'd256);
        chk("off_window_done", 64'(window_done_o), 64'd1);
        chk("off_sym_ct", 64'(inj_sym_ct_o), 64'd0);

        // Burst length 3, mask 01
        pulse_reset();
        mode_i = 2'b11; err_mask_i = 2'b01; burst_len_i = 4'd3;
        for (int i = 0; i < 40; i++) begin
            r = 2'($urandom_range(3, 0));
            send(1'b1, r);
        end
        idle(3);
        chk("burst3_bit_ct", 64'(inj_bit_ct_o), 64'd6);

        // Burst length 0 behaves as 1
        pulse_reset();
        burst_len_i = 4'd0;
        for (int i = 0; i < 40; i++) send(1'b1, 2'b10);
        idle(3);
        chk("burst0_bit_ct", 64'(inj_bit_ct_o), 64'd2);

        // Periodic with enable gaps
        pulse_reset();
        mode_i = 2'b01; err_mask_i = 2'b11;
        for (int i = 0; i < 32; i++) begin
            send(1'b1, 2'b00);
            send(1'b0, 2'b11);
        end
        idle(3);
        chk("gapped_sym_ct", 64'(inj_sym_ct_o), 64'd2);
        chk("gapped_word_ct", 64'(word_ct_o), 64'd32);

        // Random mode: thresh 0 never injects, then thresh 128 against the LFSR model
        pulse_reset();
        mode_i = 2'b10; err_mask_i = 2'b10; thresh_i = 8'd0;
        for (int i = 0; i < 100; i++) send(1'b1, 2'b01);
        idle(2);
        chk("thresh0_sym_ct", 64'(inj_sym_ct_o), 64'd0);
        thresh_i = 8'd128;
        for (int i = 0; i < 900; i++) begin
            r = 2'($urandom_range(3, 0));
            send(1'b1, r);
        end
        idle(3);

        // Reset while the burst FSM is mid-burst (after symbol 16)
        pulse_reset();
        mode_i = 2'b11; err_mask_i = 2'b11; burst_len_i = 4'd3;
        for (int i = 0; i < 17; i++) send(1'b1, 2'b00);
        pulse_reset();
        for (int i = 0; i < 40; i++) send(1'b1, 2'b00);
        idle(3);
        chk("post_reset_sym_ct", 64'(inj_sym_ct_o), 64'd6);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
